// File: rtl/router_pkg.sv
// router_pkg
// Shared definitions for the router packet source: source FSM state encoding,
// router header field widths and the reserved (invalid) destination address.
// No ports.
package router_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 2;
    localparam int LEN_W  = 6;

    // Destination 3 does not exist on the 1x3 router.
    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_PAYLOAD,
        ST_PARITY,
        ST_GAP
    } state_t;

    // Router header byte: length in the upper six bits, destination in the lower two.
    function automatic logic [DATA_W-1:0] make_header(input logic [LEN_W-1:0]  len,
                                                      input logic [ADDR_W-1:0] addr);
        return {len, addr};
    endfunction

endpackage

// File: rtl/pkt_src_buffer.sv
// pkt_src_buffer
// Circular byte FIFO that holds payload for the router packet source.
// Ports:
//   clock, resetn  - rising-edge clock, asynchronous active-low reset
//   wr_en, wr_data - push one byte; dropped while full
//   pop            - remove the head byte (ignored when empty)
//   head           - byte at the read pointer
//   head_next      - byte one past the read pointer (wraps modulo DEPTH)
//   count          - bytes currently stored (registered)
//   full           - count == DEPTH (registered)
module pkt_src_buffer
    import router_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    wr_en,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    pop,
    output logic [DATA_W-1:0]       head,
    output logic [DATA_W-1:0]       head_next,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  rd_ptr_inc;
    logic [PTR_W:0]    count_n;
    logic              wr_ok;
    logic              pop_ok;

    assign wr_ok      = wr_en && !full;
    assign pop_ok     = pop && (count != '0);
    assign rd_ptr_inc = rd_ptr + PTR_W'(1);

    // Peek at the next byte so the source can present it on the same edge
    // that pops the current one.
    assign head      = mem[rd_ptr];
    assign head_next = mem[rd_ptr_inc];

    always_comb begin
        count_n = count;
        case ({wr_ok, pop_ok})
            2'b10:   count_n = count + (PTR_W+1)'(1);
            2'b01:   count_n = count - (PTR_W+1)'(1);
            default: count_n = count;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr_inc;
            end
            count <= count_n;
            full  <= (count_n == (PTR_W+1)'(DEPTH));
        end
    end

    // Storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge clock) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/router_pkt_source.sv
// router_pkt_source
// Upstream packet source for the 1x3 router. Buffers payload bytes from a host
// write port, accepts a transmit command (destination + length) and serializes
// header, payload and parity onto the router input, stalling on busy.
// Ports:
//   clock, resetn      - rising-edge clock, asynchronous active-low reset
//   wr_en, wr_data     - payload byte write; wr_full flags dropped writes
//   buf_count          - bytes currently buffered
//   cmd_valid/addr/len - transmit request; cmd_ready is the handshake
//   cmd_err            - one-cycle pulse after an invalid command is dropped
//   busy               - router stall; outputs hold while high
//   pkt_data, pkt_valid- router data_in / pkt_valid
//   tx_active          - header, payload or parity in flight
//   pkt_done           - one-cycle pulse (GAP) after parity is taken
//   cmd_corrupt        - only with PKT_SRC_ERR_INJECT_EN: flip parity bit 0
// Optional feature macro: PKT_SRC_ERR_INJECT_EN
module router_pkt_source
    import router_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   wr_en,
    input  logic [DATA_W-1:0]      wr_data,
    output logic                   wr_full,
    output logic [$clog2(DEPTH):0] buf_count,
    input  logic                   cmd_valid,
    input  logic [ADDR_W-1:0]      cmd_addr,
    input  logic [LEN_W-1:0]       cmd_len,
    output logic                   cmd_ready,
    output logic                   cmd_err,
    input  logic                   busy,
    output logic [DATA_W-1:0]      pkt_data,
    output logic                   pkt_valid,
    output logic                   tx_active,
    output logic                   pkt_done
`ifdef PKT_SRC_ERR_INJECT_EN
   ,input  logic                   cmd_corrupt
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    state_t            state, state_n;
    logic [LEN_W-1:0]  cnt_q, cnt_n;
    logic [DATA_W-1:0] parity_q, parity_n;
    logic              corrupt_q, corrupt_n;
    logic [DATA_W-1:0] data_n;
    logic              valid_n;
    logic              tx_n;
    logic              done_n;
    logic              err_n;
    logic              pop;
    logic              cmd_invalid;
    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] head_next;

    pkt_src_buffer #(
        .DEPTH (DEPTH)
    ) u_buffer (
        .clock     (clock),
        .resetn    (resetn),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .pop       (pop),
        .head      (head),
        .head_next (head_next),
        .count     (buf_count),
        .full      (wr_full)
    );

    assign cmd_invalid = (cmd_addr == ADDR_INVALID) || (cmd_len == '0);

    // Invalid commands are always consumed so they never block the port.
    assign cmd_ready = (state == ST_IDLE) &&
                       (cmd_invalid || (buf_count >= {{(CNT_W-LEN_W){1'b0}}, cmd_len}));

    always_comb begin
        state_n   = state;
        cnt_n     = cnt_q;
        parity_n  = parity_q;
        corrupt_n = corrupt_q;
        data_n    = pkt_data;
        valid_n   = pkt_valid;
        done_n    = 1'b0;
        err_n     = 1'b0;
        pop       = 1'b0;

        case (state)
            ST_IDLE: begin
                data_n  = '0;
                valid_n = 1'b0;
                if (cmd_valid && cmd_ready) begin
                    if (cmd_invalid) begin
                        err_n = 1'b1;
                    end else begin
                        // The header register itself latches addr/len.
                        state_n  = ST_HEADER;
                        cnt_n    = cmd_len - LEN_W'(1);
                        parity_n = '0;
`ifdef PKT_SRC_ERR_INJECT_EN
                        corrupt_n = cmd_corrupt;
`else
                        corrupt_n = 1'b0;
`endif
                        data_n   = make_header(cmd_len, cmd_addr);
                        valid_n  = 1'b1;
                    end
                end
            end

            ST_HEADER: begin
                if (!busy) begin
                    parity_n = parity_q ^ pkt_data;
                    state_n  = ST_PAYLOAD;
                    data_n   = head;
                    valid_n  = 1'b1;
                end
            end

            ST_PAYLOAD: begin
                if (!busy) begin
                    pop      = 1'b1;
                    parity_n = parity_q ^ pkt_data;
                    if (cnt_q == '0) begin
                        state_n = ST_PARITY;
                        data_n  = parity_q ^ pkt_data ^ {{(DATA_W-1){1'b0}}, corrupt_q};
                        valid_n = 1'b0;
                    end else begin
                        // The current head is popped on this edge, so the
                        // byte behind it becomes the new output.
                        cnt_n   = cnt_q - LEN_W'(1);
                        data_n  = head_next;
                        valid_n = 1'b1;
                    end
                end
            end

            ST_PARITY: begin
                if (!busy) begin
                    state_n = ST_GAP;
                    data_n  = '0;
                    valid_n = 1'b0;
                    done_n  = 1'b1;
                end
            end

            ST_GAP: begin
                state_n = ST_IDLE;
                data_n  = '0;
                valid_n = 1'b0;
            end

            default: begin
                state_n = ST_IDLE;
                data_n  = '0;
                valid_n = 1'b0;
            end
        endcase

        tx_n = (state_n == ST_HEADER) || (state_n == ST_PAYLOAD) || (state_n == ST_PARITY);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            cnt_q     <= '0;
            parity_q  <= '0;
            corrupt_q <= 1'b0;
            pkt_data  <= '0;
            pkt_valid <= 1'b0;
            tx_active <= 1'b0;
            pkt_done  <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            state     <= state_n;
            cnt_q     <= cnt_n;
            parity_q  <= parity_n;
            corrupt_q <= corrupt_n;
            pkt_data  <= data_n;
            pkt_valid <= valid_n;
            tx_active <= tx_n;
            pkt_done  <= done_n;
            cmd_err   <= err_n;
        end
    end

endmodule
